// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end:
// the FSM encoding and the NOP that IF/ID sees while nothing has been fetched.
package fetch_prefetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam int              INST_W   = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Show-ahead FIFO for fetched {instruction, pc} pairs. The head entry is
// visible on rdata whenever it is non-empty. Flush empties it in one cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage is not reset; cnt decides validity, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt;
    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding reads
// on granted cycles, buffers responses and hands them to IF/ID via valid/ready.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter int               ADDR_W   = 8,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_gnt,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              halt,
    input  logic              inst_ready,
    output logic              inst_valid,
    output logic [XLEN-1:0]   inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic [XLEN-1:0]   inst_pc4
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic [XLEN-1:0]   fpc;
    logic [XLEN-1:0]   pending_pc;
    logic              inflight;
    logic              drop;

    logic              take_redirect;
    logic              credit_ok;
    logic              rsp_push;
    logic              fifo_pop;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [2*XLEN-1:0] fifo_head;
    logic [XLEN-1:0]   head_inst;
    logic [XLEN-1:0]   head_pc;
    logic [XLEN-1:0]   head_pc4;
    logic [XLEN-1:0]   held_inst;
    logic [XLEN-1:0]   held_pc;
    logic [XLEN-1:0]   held_pc4;

    // Halt outranks redirect; once halted the pipeline only drains.
    assign take_redirect = redirect & ~halt & (state != ST_HALTED);
    // In-flight words already own a slot, so the FIFO can never overflow.
    assign credit_ok     = (32'(fifo_count) + 32'(inflight)) < 32'(DEPTH);
    assign rsp_push      = mem_rvalid & ~drop & ~take_redirect;
    assign fifo_pop      = inst_valid & inst_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_next = state;
        mem_req    = 1'b0;
        case (state)
            ST_IDLE:   state_next = ST_FETCH;
            ST_FETCH: begin
                if (halt) state_next = ST_HALTED;
                mem_req = mem_gnt & ~redirect & ~halt & credit_ok;
            end
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc        <= RESET_PC;
            pending_pc <= '0;
            inflight   <= 1'b0;
            drop       <= 1'b0;
        end else if (take_redirect) begin
            fpc      <= redirect_pc & ~XLEN'(3);
            drop     <= inflight & ~mem_rvalid;
            inflight <= inflight & ~mem_rvalid;
        end else begin
            if (mem_rvalid) begin
                inflight <= 1'b0;
                drop     <= 1'b0;
            end
            // NOTE: the last non-blocking assignment wins, so a new request re-arms
            // inflight in the same cycle the previous response retires.
            if (mem_req) begin
                inflight   <= 1'b1;
                pending_pc <= fpc;
                fpc        <= fpc + XLEN'(4);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_push),
        .pop   (fifo_pop),
        .flush (take_redirect),
        .wdata ({mem_rdata, pending_pc}),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_inst = fifo_head[2*XLEN-1:XLEN];
    assign head_pc   = fifo_head[XLEN-1:0];
    assign head_pc4  = head_pc + XLEN'(4);

    // Outputs keep showing the last head while the FIFO is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_inst <= XLEN'(NOP_INST);
            held_pc   <= '0;
            held_pc4  <= '0;
        end else if (inst_valid) begin
            held_inst <= head_inst;
            held_pc   <= head_pc;
            held_pc4  <= head_pc4;
        end
    end

    assign inst_valid = ~fifo_empty;
    assign inst       = inst_valid ? head_inst : held_inst;
    assign inst_pc    = inst_valid ? head_pc   : held_pc;
    assign inst_pc4   = inst_valid ? head_pc4  : held_pc4;
    assign mem_addr   = fpc[ADDR_W-1:0];

    push_never_full: assert property (@(posedge clk) disable iff (!rst) !(rsp_push && fifo_full));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: streaming table, backpressure,
// grant gaps, redirects, halt draining and asynchronous reset mid-stream.
module tb_fetch_prefetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_gnt;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  req_log[$];
    logic [31:0] pop_log[$];

    typedef struct {
        logic        gnt;
        logic        ready;
        logic        exp_req;
        logic [7:0]  exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[10];

    fetch_prefetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .mem_gnt     (mem_gnt),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .inst_ready  (inst_ready),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_pc4    (inst_pc4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: log request/pop, then play the memory (response one cycle after a request).
    task automatic step();
        logic       q;
        logic [7:0] a;
        q = mem_req;
        a = mem_addr;
        if (mem_req) req_log.push_back(mem_addr);
        if (inst_valid && inst_ready) begin
            pop_log.push_back(inst_pc);
            check("pop_inst", inst, rdata_of(inst_pc));
            check("pop_pc4", inst_pc4, inst_pc + 32'd4);
        end
        @(posedge clk);
        #1;
        mem_rvalid = q && rst;
        mem_rdata  = rdata_of({24'h0, a});
    endtask

    task automatic hold_reset();
        rst         = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        mem_gnt     = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        step();
        step();
    endtask

    task automatic release_reset();
        rst = 1'b1;
        req_log.delete();
        pop_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          gnt ready req  addr   valid pc
        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h00};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 32'h00};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h04, 1'b0, 32'h00};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 8'h08, 1'b1, 32'h00};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h0C, 1'b1, 32'h04};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 32'h08};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h14, 1'b1, 32'h08};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h08};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 8'h18, 1'b1, 32'h0C};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 8'h1C, 1'b1, 32'h10};

        // Reset values
        hold_reset();
        check("rst_valid", inst_valid, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_inst", inst, NOP);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_pc4", inst_pc4, 32'h0);
        release_reset();

        // Streaming and short backpressure, table-driven
        for (int i = 0; i < 10; i++) begin
            mem_gnt    = vecs[i].gnt;
            inst_ready = vecs[i].ready;
            #1;
            check($sformatf("v%0d_req", i), mem_req, vecs[i].exp_req);
            if (vecs[i].exp_req) check($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_valid", i), inst_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_pc", i), inst_pc, vecs[i].exp_pc);
                check($sformatf("v%0d_inst", i), inst, rdata_of(vecs[i].exp_pc));
                check($sformatf("v%0d_pc4", i), inst_pc4, vecs[i].exp_pc + 32'd4);
            end
            step();
        end

        // Stalled from the start: exactly DEPTH requests, then drain and resume at 0x10
        hold_reset();
        release_reset();
        mem_gnt = 1'b1;
        repeat (10) step();
        check("stall_req_count", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("stall_addr%0d", i), req_log[i], 8'(4 * i));
        check("stall_no_req", mem_req, 1'b0);
        check("stall_valid", inst_valid, 1'b1);
        check("stall_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        repeat (8) step();
        for (int i = 0; i < 5; i++) check($sformatf("drain_pc%0d", i), pop_log[i], 32'(4 * i));
        check("resume_addr", req_log[4], 8'h10);

        // Grant toggling: requests only in granted cycles, contiguous addresses
        hold_reset();
        release_reset();
        mem_gnt    = 1'b1;
        inst_ready = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
            mem_gnt = (i % 2 == 0);
            #1;
            if (!mem_gnt) check($sformatf("gnt_off_req%0d", i), mem_req, 1'b0);
            step();
        end
        mem_gnt = 1'b0;
        repeat (4) step();
        check("gnt_req_count", 32'(req_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("gnt_addr%0d", i), req_log[i], 8'(4 * i));
        check("gnt_pop_count", 32'(pop_log.size()), 32'd6);
        check("gnt_pop_last", pop_log[5], 32'h14);

        // Redirect in the cycle the 0x08 response returns
        hold_reset();
        release_reset();
        mem_gnt    = 1'b1;
        inst_ready = 1'b1;
        step();
        step();
        step();
        #1;
        check("redir_pre_req", mem_req, 1'b1);
        check("redir_pre_addr", mem_addr, 8'h08);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("redir_no_req", mem_req, 1'b0);
        step();
        redirect = 1'b0;
        #1;
        check("redir_flushed", inst_valid, 1'b0);
        check("redir_req", mem_req, 1'b1);
        check("redir_addr", mem_addr, 8'h40);
        step();
        step();
        #1;
        check("redir_valid", inst_valid, 1'b1);
        check("redir_pc", inst_pc, 32'h40);
        check("redir_inst", inst, rdata_of(32'h40));
        begin
            int n8 = 0;
            foreach (pop_log[i]) if (pop_log[i] == 32'h08) n8++;
            check("redir_drop_08", 32'(n8), 32'd0);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        #1;
        check("misalign_no_req", mem_req, 1'b0);
        step();
        redirect = 1'b0;
        #1;
        check("misalign_req", mem_req, 1'b1);
        check("misalign_addr", mem_addr, 8'h40);
        step();
        step();
        #1;
        check("misalign_pc", inst_pc, 32'h40);

        // Halt (with simultaneous redirect) while 2 buffered and 1 in flight
        hold_reset();
        release_reset();
        mem_gnt = 1'b1;
        repeat (4) step();
        #1;
        check("halt_pre_req", mem_req, 1'b1);
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        #1;
        check("halt_no_req", mem_req, 1'b0);
        step();
        halt       = 1'b0;
        redirect   = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("halted_req%0d", i), mem_req, 1'b0);
            step();
        end
        check("halt_req_count", 32'(req_log.size()), 32'd3);
        check("halt_pop_count", 32'(pop_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) check($sformatf("halt_pop%0d", i), pop_log[i], 32'(4 * i));
        check("halt_empty", inst_valid, 1'b0);

        // Asynchronous reset with a response pending
        hold_reset();
        release_reset();
        mem_gnt = 1'b1;
        repeat (3) step();
        #1;
        check("arst_pre_valid", inst_valid, 1'b1);
        rst = 1'b0;
        #1;
        check("arst_valid", inst_valid, 1'b0);
        check("arst_inst", inst, NOP);
        check("arst_pc", inst_pc, 32'h0);
        check("arst_pc4", inst_pc4, 32'h0);
        check("arst_req", mem_req, 1'b0);
        step();
        step();
        release_reset();
        inst_ready = 1'b1;
        step();
        #1;
        check("arst_restart_req", mem_req, 1'b1);
        check("arst_restart_addr", mem_addr, 8'h00);
        repeat (4) step();
        check("arst_pop0", pop_log[0], 32'h0);
        check("arst_pop1", pop_log[1], 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
